// File: rtl/modality_memory_server_pkg.sv
// rtl/modality_memory_server_pkg.sv - shared types and helpers for the per-modality memory server
package modality_memory_server_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_IM   = 2'd0,
        SEL_NEG  = 2'd1,
        SEL_POS  = 2'd2,
        SEL_NONE = 2'd3
    } load_sel_e;

    // Never returns less than 1 so single-entry ranges still get a real bit.
    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hv_sram_bank.sv
// rtl/hv_sram_bank.sv - single-port row bank, synchronous write, pipelined registered read
module hv_sram_bank #(
    parameter int WIDTH        = 2000,
    parameter int DEPTH        = 32,
    parameter int AW           = 5,
    parameter int READ_LATENCY = 1
) (
    input  logic             Clk_CI,
    input  logic             WrEn_SI,
    input  logic             RdEn_SI,
    input  logic [AW-1:0]    Addr_DI,
    input  logic [WIDTH-1:0] WrData_DI,
    output logic [WIDTH-1:0] RdData_DO
);

    logic [WIDTH-1:0] mem_q  [DEPTH];
    logic [WIDTH-1:0] pipe_q [READ_LATENCY];

    // Stage 0 only loads on a read; later stages always shift.
    always_ff @(posedge Clk_CI) begin
        if (WrEn_SI) begin
            mem_q[Addr_DI] <= WrData_DI;
        end
        if (RdEn_SI) begin
            pipe_q[0] <= mem_q[Addr_DI];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign RdData_DO = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/modality_memory_server.sv
// rtl/modality_memory_server.sv - serves iM/projM rows for one modality to the spatial encoder
module modality_memory_server
    import modality_memory_server_pkg::*;
#(
    parameter int HV_DIMENSION = 2000,
    parameter int DEPTH        = 32,
    parameter int BASE_ADDR    = 0,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                         Clk_CI,
    input  logic                         Reset_RI,
    input  logic                         ReqValid_SI,
    input  logic                         ReqReady_SI,
    input  logic [ADDR_WIDTH-1:0]        Addr_DI,
    output logic                         SramValid_SO,
    output logic                         SramReady_SO,
    output logic [HV_DIMENSION-1:0]      IMOut_DO,
    output logic [HV_DIMENSION-1:0]      ProjNeg_DO,
    output logic [HV_DIMENSION-1:0]      ProjPos_DO,
    input  logic                         LoadValid_SI,
    output logic                         LoadReady_SO,
    input  logic [1:0]                   LoadSel_DI,
    input  logic [ceil_log2(DEPTH)-1:0]  LoadAddr_DI,
    input  logic [HV_DIMENSION-1:0]      LoadData_DI
);

    localparam int AW    = ceil_log2(DEPTH);
    localparam int CNT_W = ceil_log2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LATENCY - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic                    in_range_q, in_range_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [HV_DIMENSION-1:0] im_q, im_d, neg_q, neg_d, pos_q, pos_d;
    logic [HV_DIMENSION-1:0] im_rd, neg_rd, pos_rd;
    logic                    req_in_range, launch, rd_en, load_fire;
    logic [AW-1:0]           req_row, bank_addr;
    logic [2:0]              bank_we;
    logic                    unused_req_ready;

    assign unused_req_ready = ReqReady_SI;

    assign req_in_range = (int'(Addr_DI) >= BASE_ADDR) && (int'(Addr_DI) < BASE_ADDR + DEPTH);
    assign req_row      = AW'(Addr_DI - ADDR_WIDTH'(BASE_ADDR));

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        in_range_d   = in_range_q;
        cnt_d        = cnt_q;
        im_d         = im_q;
        neg_d        = neg_q;
        pos_d        = pos_q;
        launch       = 1'b0;
        rd_en        = 1'b0;
        SramValid_SO = 1'b0;
        LoadReady_SO = 1'b0;
        case (state_q)
            ST_IDLE: begin
                LoadReady_SO = LoadValid_SI && !ReqValid_SI;
                launch       = ReqValid_SI;
            end
            ST_FETCH: begin
                if (!ReqValid_SI) begin
                    state_d = ST_IDLE;
                end else if (Addr_DI != cur_addr_q) begin
                    launch = 1'b1;
                end else if (cnt_q == LAST_CNT) begin
                    im_d    = in_range_q ? im_rd  : '0;
                    neg_d   = in_range_q ? neg_rd : '0;
                    pos_d   = in_range_q ? pos_rd : '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                SramValid_SO = ReqValid_SI && (Addr_DI == cur_addr_q);
                if (!ReqValid_SI) begin
                    state_d = ST_IDLE;
                end else if (Addr_DI != cur_addr_q) begin
                    launch = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new address always restarts the fetch, aborting any read in flight.
        if (launch) begin
            cur_addr_d = Addr_DI;
            in_range_d = req_in_range;
            rd_en      = req_in_range;
            cnt_d      = '0;
            state_d    = ST_FETCH;
        end
    end

    assign load_fire    = LoadValid_SI && LoadReady_SO;
    assign SramReady_SO = !load_fire;
    assign bank_we[0]   = load_fire && (LoadSel_DI == SEL_IM);
    assign bank_we[1]   = load_fire && (LoadSel_DI == SEL_NEG);
    assign bank_we[2]   = load_fire && (LoadSel_DI == SEL_POS);
    assign bank_addr    = rd_en ? req_row : LoadAddr_DI;

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            in_range_q <= 1'b0;
            cnt_q      <= '0;
            im_q       <= '0;
            neg_q      <= '0;
            pos_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            in_range_q <= in_range_d;
            cnt_q      <= cnt_d;
            im_q       <= im_d;
            neg_q      <= neg_d;
            pos_q      <= pos_d;
        end
    end

    hv_sram_bank #(.WIDTH(HV_DIMENSION), .DEPTH(DEPTH), .AW(AW), .READ_LATENCY(READ_LATENCY)) u_bank_im (
        .Clk_CI(Clk_CI), .WrEn_SI(bank_we[0]), .RdEn_SI(rd_en), .Addr_DI(bank_addr),
        .WrData_DI(LoadData_DI), .RdData_DO(im_rd)
    );

    hv_sram_bank #(.WIDTH(HV_DIMENSION), .DEPTH(DEPTH), .AW(AW), .READ_LATENCY(READ_LATENCY)) u_bank_neg (
        .Clk_CI(Clk_CI), .WrEn_SI(bank_we[1]), .RdEn_SI(rd_en), .Addr_DI(bank_addr),
        .WrData_DI(LoadData_DI), .RdData_DO(neg_rd)
    );

    hv_sram_bank #(.WIDTH(HV_DIMENSION), .DEPTH(DEPTH), .AW(AW), .READ_LATENCY(READ_LATENCY)) u_bank_pos (
        .Clk_CI(Clk_CI), .WrEn_SI(bank_we[2]), .RdEn_SI(rd_en), .Addr_DI(bank_addr),
        .WrData_DI(LoadData_DI), .RdData_DO(pos_rd)
    );

    assign IMOut_DO   = im_q;
    assign ProjNeg_DO = neg_q;
    assign ProjPos_DO = pos_q;

endmodule
